// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate codes, LPIF state codes and PIPE width codes.
package ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET   = 4'd0,
    DETECT_ACTIVE  = 4'd1,
    POLLING_ACTIVE = 4'd2,
    POLLING_CONFIG = 4'd3,
    CFG_LW_START   = 4'd4,
    CFG_LW_ACCEPT  = 4'd5,
    CFG_LN_WAIT    = 4'd6,
    CFG_LN_ACCEPT  = 4'd7,
    CFG_COMPLETE   = 4'd8,
    CFG_IDLE       = 4'd9,
    L0             = 4'd10,
    RCVR_LOCK      = 4'd11,
    RCVR_CFG       = 4'd12,
    RCVR_IDLE      = 4'd13
  } substate_e;

  localparam logic [3:0] LPIF_RESET   = 4'd0;
  localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
  localparam logic [3:0] LPIF_RETRAIN = 4'd2;

  localparam logic [1:0] WIDTH_8  = 2'd0;
  localparam logic [1:0] WIDTH_16 = 2'd1;
  localparam logic [1:0] WIDTH_32 = 2'd2;

  // Map a PIPE data width in bits to its width code; unknown widths read as 8 bit.
  function automatic logic [1:0] width_enc(input int unsigned bits);
    case (bits)
      16:      return WIDTH_16;
      32:      return WIDTH_32;
      default: return WIDTH_8;
    endcase
  endfunction

endpackage

// File: rtl/ltssm_link_ctrl_if.sv
// Handshake and status bundle between the LTSSM coordinator and its PHY-side users.
interface ltssm_link_ctrl_if #(
  parameter int unsigned NUM_LANES = 16
);
  logic [3:0]           lpif_state_req;
  logic                 finish_tx;
  logic                 finish_rx;
  logic [3:0]           goto_tx;
  logic [3:0]           goto_rx;
  logic                 force_detect;
  logic [NUM_LANES-1:0] lane_mask;
  logic                 lane_mask_valid;
  logic [2:0]           target_gen;
  logic [3:0]           substate;
  logic [3:0]           lpif_state_sts;
  logic                 link_up;
  logic [2:0]           gen;
  logic [1:0]           width;
  logic [4:0]           num_lanes;
  logic                 timeout_evt;

  modport master (
    output lpif_state_req, finish_tx, finish_rx, goto_tx, goto_rx, force_detect,
           lane_mask, lane_mask_valid, target_gen,
    input  substate, lpif_state_sts, link_up, gen, width, num_lanes, timeout_evt
  );

  modport slave (
    input  lpif_state_req, finish_tx, finish_rx, goto_tx, goto_rx, force_detect,
           lane_mask, lane_mask_valid, target_gen,
    output substate, lpif_state_sts, link_up, gen, width, num_lanes, timeout_evt
  );
endinterface

// File: rtl/ltssm_timeout_cnt.sv
// Per-substate timeout counter: cleared on substate change, counts while enabled,
// flags the terminal count so the coordinator can leave the substate.
module ltssm_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment, hold when disabled.
  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks keep register updates order-independent.
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign term_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/ltssm_link_ctrl.sv
// Top-level LTSSM coordinator: sequences Tx/Rx sub-machines from Detect to L0,
// handles Recovery with generation change, timeouts, lane capture and LPIF status.
module ltssm_link_ctrl
  import ltssm_pkg::*;
#(
  parameter int unsigned DEVICETYPE     = 0,
  parameter int unsigned NUM_LANES      = 16,
  parameter int unsigned MAX_GEN        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 24000,
  parameter int unsigned GEN1_PIPEWIDTH = 8,
  parameter int unsigned GEN2_PIPEWIDTH = 8,
  parameter int unsigned GEN3_PIPEWIDTH = 8,
  parameter int unsigned GEN4_PIPEWIDTH = 8,
  parameter int unsigned GEN5_PIPEWIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  ltssm_link_ctrl_if.slave bus
);

  localparam logic [1:0] WIDTH_RST = width_enc(GEN1_PIPEWIDTH);

  substate_e            sub_q, sub_d, fwd_tgt;
  logic [3:0]           sts_q, sts_d;
  logic                 link_up_q, link_up_d;
  logic [2:0]           gen_q, gen_d;
  logic [1:0]           width_q, width_d;
  logic [4:0]           nl_q, nl_d;
  logic                 evt_q, evt_d;
  logic                 tx_hit, rx_hit, both_hit, either_hit, fb_hit, fwd_ok;
  logic                 to_term, to_exit, to_clr, to_en, gen_ok;
  logic [NUM_LANES-1:0] lane_mask;

  assign lane_mask = bus.lane_mask;

  // PIPE width configured for a generation; out-of-range generations use Gen1.
  function automatic int unsigned pipe_width(input logic [2:0] g);
    case (g)
      3'd2:    return GEN2_PIPEWIDTH;
      3'd3:    return GEN3_PIPEWIDTH;
      3'd4:    return GEN4_PIPEWIDTH;
      3'd5:    return GEN5_PIPEWIDTH;
      default: return GEN1_PIPEWIDTH;
    endcase
  endfunction

  // Forward target and handshake qualification for the current substate.
  always_comb begin
    fwd_tgt    = (sub_q == RCVR_IDLE) ? L0 : substate_e'(sub_q + 4'd1);
    tx_hit     = bus.finish_tx && (bus.goto_tx == fwd_tgt);
    rx_hit     = bus.finish_rx && (bus.goto_rx == fwd_tgt);
    both_hit   = tx_hit && rx_hit;
    either_hit = tx_hit || rx_hit;
    fb_hit     = (sub_q != DETECT_QUIET) && (sub_q != L0) &&
                 ((bus.finish_tx && bus.goto_tx == 4'd0) ||
                  (bus.finish_rx && bus.goto_rx == 4'd0));
    case (sub_q)
      DETECT_QUIET:   fwd_ok = rx_hit;
      DETECT_ACTIVE:  fwd_ok = both_hit && (nl_q != 5'd0);
      POLLING_ACTIVE: fwd_ok = either_hit;
      CFG_LW_ACCEPT:  fwd_ok = (DEVICETYPE == 0) ? tx_hit : both_hit;
      CFG_IDLE:       fwd_ok = both_hit && (bus.lpif_state_req == LPIF_ACTIVE);
      L0:             fwd_ok = (bus.lpif_state_req == LPIF_RETRAIN);
      CFG_LW_START, CFG_LN_WAIT, CFG_LN_ACCEPT, RCVR_LOCK:
                      fwd_ok = rx_hit;
      POLLING_CONFIG, CFG_COMPLETE, RCVR_CFG, RCVR_IDLE:
                      fwd_ok = both_hit;
      default:        fwd_ok = 1'b0;
    endcase
  end

  // Next substate: force, fallback, LPIF reset, forward exit, then timeout.
  always_comb begin
    sub_d   = sub_q;
    to_exit = 1'b0;
    if (bus.force_detect || fb_hit) begin
      sub_d = DETECT_QUIET;
    end else if (sub_q == L0 && bus.lpif_state_req == LPIF_RESET) begin
      sub_d = DETECT_QUIET;
    end else if (fwd_ok) begin
      sub_d = fwd_tgt;
    end else if (to_term) begin
      if (sub_q == DETECT_QUIET) begin
        sub_d = DETECT_ACTIVE;
      end else begin
        sub_d   = DETECT_QUIET;
        to_exit = 1'b1;
      end
    end
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    gen_ok = (bus.target_gen != 3'd0) && (32'(bus.target_gen) <= MAX_GEN);

    case (sub_d)
      L0:                            sts_d = LPIF_ACTIVE;
      RCVR_LOCK, RCVR_CFG, RCVR_IDLE: sts_d = LPIF_RETRAIN;
      default:                       sts_d = LPIF_RESET;
    endcase

    link_up_d = link_up_q;
    if (sub_d == DETECT_QUIET)                  link_up_d = 1'b0;
    else if (sub_q == CFG_IDLE && sub_d == L0)  link_up_d = 1'b1;

    gen_d = gen_q;
    if (sub_d == DETECT_QUIET)                                 gen_d = 3'd1;
    else if (sub_q == RCVR_CFG && sub_d == RCVR_IDLE && gen_ok) gen_d = bus.target_gen;

    nl_d = nl_q;
    if (sub_q == DETECT_ACTIVE && bus.lane_mask_valid) nl_d = 5'($countones(lane_mask));

    width_d = width_enc(pipe_width(gen_q));
    evt_d   = to_exit;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_q     <= DETECT_QUIET;
      sts_q     <= LPIF_RESET;
      link_up_q <= 1'b0;
      gen_q     <= 3'd1;
      width_q   <= WIDTH_RST;
      nl_q      <= 5'd0;
      evt_q     <= 1'b0;
    end else begin
      sub_q     <= sub_d;
      sts_q     <= sts_d;
      link_up_q <= link_up_d;
      gen_q     <= gen_d;
      width_q   <= width_d;
      nl_q      <= nl_d;
      evt_q     <= evt_d;
    end
  end

  assign to_clr = bus.force_detect || (sub_d != sub_q);
  assign to_en  = (sub_q != L0);

  ltssm_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (to_clr),
    .en_i  (to_en),
    .term_o(to_term)
  );

  assign bus.substate       = sub_q;
  assign bus.lpif_state_sts = sts_q;
  assign bus.link_up        = link_up_q;
  assign bus.gen            = gen_q;
  assign bus.width          = width_q;
  assign bus.num_lanes      = nl_q;
  assign bus.timeout_evt    = evt_q;

endmodule

// File: tb/tb_ltssm_link_ctrl.sv
// Scoreboard bench for ltssm_link_ctrl: expected output snapshots are queued as
// each cycle's stimulus is driven and compared one clock edge later.
module tb_ltssm_link_ctrl;

  localparam int unsigned NL = 16;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ltssm_link_ctrl_if #(.NUM_LANES(NL)) bus ();

  ltssm_link_ctrl #(
    .DEVICETYPE    (0),
    .NUM_LANES     (NL),
    .MAX_GEN       (5),
    .TIMEOUT_CYCLES(TO),
    .GEN1_PIPEWIDTH(8),
    .GEN2_PIPEWIDTH(16),
    .GEN3_PIPEWIDTH(32),
    .GEN4_PIPEWIDTH(32),
    .GEN5_PIPEWIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] sub;
    logic [3:0] sts;
    logic       lu;
    logic [2:0] gen;
    logic [1:0] wid;
    logic [4:0] nl;
    logic       evt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Expected output state, updated by the stimulus sequence.
  logic [3:0] e_sub = 4'd0;
  logic [3:0] e_sts = 4'd0;
  logic       e_lu  = 1'b0;
  logic [2:0] e_gen = 3'd1;
  logic [1:0] e_wid = 2'd0;
  logic [4:0] e_nl  = 5'd0;
  logic       e_evt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag; e.sub = e_sub; e.sts = e_sts; e.lu = e_lu;
    e.gen = e_gen; e.wid = e_wid; e.nl = e_nl; e.evt = e_evt;
    sb.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, ".substate"},  32'(bus.substate),       32'(e.sub));
    check({e.tag, ".lpif_sts"},  32'(bus.lpif_state_sts), 32'(e.sts));
    check({e.tag, ".link_up"},   32'(bus.link_up),        32'(e.lu));
    check({e.tag, ".gen"},       32'(bus.gen),            32'(e.gen));
    check({e.tag, ".width"},     32'(bus.width),          32'(e.wid));
    check({e.tag, ".num_lanes"}, 32'(bus.num_lanes),      32'(e.nl));
    check({e.tag, ".timeout"},   32'(bus.timeout_evt),    32'(e.evt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_now();
    bus.finish_tx       = 1'b0;
    bus.finish_rx       = 1'b0;
    bus.lane_mask_valid = 1'b0;
    bus.force_detect    = 1'b0;
    e_evt               = 1'b0;
  endtask

  task automatic step(input string tag, input logic [3:0] nsub);
    e_sub = nsub;
    push(tag);
    tick();
  endtask

  task automatic hs(input string tag, input logic tx, input logic rx,
                    input logic [3:0] g, input logic [3:0] nsub);
    bus.finish_tx = tx; bus.goto_tx = g;
    bus.finish_rx = rx; bus.goto_rx = g;
    step(tag, nsub);
  endtask

  // Walk from detectActive (lanes captured) forward up to substate `last` (2..9).
  task automatic train_to(input int last);
    logic [9:0] tx_m, rx_m;
    tx_m = 10'b1001_0111_00;
    rx_m = 10'b1110_1101_00;
    for (int s = 2; s <= last; s++)
      hs($sformatf("train%0d", s), tx_m[s], rx_m[s], 4'(s), 4'(s));
  endtask

  task automatic enter_l0();
    bus.lpif_state_req = 4'd1;
    e_lu = 1'b1; e_sts = 4'd1;
    hs("enter_l0", 1'b1, 1'b1, 4'd10, 4'd10);
  endtask

  // L0 -> rcvrLock -> rcvrCfg -> rcvrIdle -> L0 with a requested generation.
  task automatic retrain(input logic [2:0] tg, input logic [2:0] exp_gen, input logic [1:0] exp_wid);
    bus.lpif_state_req = 4'd2;
    e_sts = 4'd2;
    step($sformatf("rl_g%0d", tg), 4'd11);
    bus.lpif_state_req = 4'd1;
    hs($sformatf("rc_g%0d", tg), 1'b0, 1'b1, 4'd12, 4'd12);
    bus.target_gen = tg;
    e_gen = exp_gen;
    hs($sformatf("ri_g%0d", tg), 1'b1, 1'b1, 4'd13, 4'd13);
    e_sts = 4'd1;
    e_wid = exp_wid;
    hs($sformatf("ret_l0_g%0d", tg), 1'b1, 1'b1, 4'd10, 4'd10);
  endtask

  initial begin
    bus.lpif_state_req  = 4'd0;
    bus.finish_tx       = 1'b0;
    bus.finish_rx       = 1'b0;
    bus.goto_tx         = 4'd0;
    bus.goto_rx         = 4'd0;
    bus.force_detect    = 1'b0;
    bus.lane_mask       = '0;
    bus.lane_mask_valid = 1'b0;
    bus.target_gen      = 3'd1;

    #12;
    push("reset");
    compare_now();
    #10 reset = 1'b1;

    // Full training with a couple of blocked exits along the way.
    hs("dq_to_da", 1'b0, 1'b1, 4'd1, 4'd1);
    hs("da_nolanes", 1'b1, 1'b1, 4'd2, 4'd1);
    bus.lane_mask = 16'h00FF; bus.lane_mask_valid = 1'b1; e_nl = 5'd8;
    step("lane_cap", 4'd1);
    hs("pa", 1'b1, 1'b1, 4'd2, 4'd2);
    bus.lane_mask = 16'hFFFF; bus.lane_mask_valid = 1'b1;
    step("lane_ignored", 4'd2);
    hs("pc_tx_only", 1'b1, 1'b0, 4'd3, 4'd3);
    hs("lws", 1'b1, 1'b1, 4'd4, 4'd4);
    hs("lwa_tx_blocked", 1'b1, 1'b0, 4'd5, 4'd4);
    hs("lwa", 1'b0, 1'b1, 4'd5, 4'd5);
    hs("lnw_tx_only", 1'b1, 1'b0, 4'd6, 4'd6);
    hs("lna", 1'b0, 1'b1, 4'd7, 4'd7);
    hs("cc", 1'b0, 1'b1, 4'd8, 4'd8);
    hs("ci", 1'b1, 1'b1, 4'd9, 4'd9);
    hs("l0_no_req", 1'b1, 1'b1, 4'd10, 4'd9);
    enter_l0();
    for (int i = 0; i < 20; i++) step("l0_hold", 4'd10);

    // Recovery with a generation change, then an out-of-range request.
    retrain(3'd3, 3'd3, 2'd2);
    retrain(3'd7, 3'd3, 2'd2);

    // LPIF reset request drops the link; width follows gen one cycle later.
    bus.lpif_state_req = 4'd0;
    e_sts = 4'd0; e_lu = 1'b0; e_gen = 3'd1;
    step("l0_exit", 4'd0);
    e_wid = 2'd0;
    step("l0_exit_wid", 4'd0);

    // Fallback beats the forward exit in cfgComplete.
    hs("dq_to_da2", 1'b0, 1'b1, 4'd1, 4'd1);
    train_to(8);
    bus.finish_tx = 1'b1; bus.goto_tx = 4'd9;
    bus.finish_rx = 1'b1; bus.goto_rx = 4'd0;
    step("fallback", 4'd0);

    // Timeout while stalled in pollingActive.
    hs("dq_to_da3", 1'b0, 1'b1, 4'd1, 4'd1);
    train_to(2);
    for (int i = 0; i < int'(TO) - 1; i++) step("pa_stall", 4'd2);
    e_evt = 1'b1;
    step("pa_timeout", 4'd0);
    step("evt_cleared", 4'd0);

    // detectQuiet times out forward to detectActive without an event.
    for (int i = 0; i < int'(TO) - 2; i++) step("dq_wait", 4'd0);
    step("dq_timeout", 4'd1);

    // force_detect in rcvrCfg outranks a concurrent forward handshake.
    train_to(9);
    enter_l0();
    retrain(3'd2, 3'd2, 2'd1);
    bus.lpif_state_req = 4'd2;
    e_sts = 4'd2;
    step("rl_f", 4'd11);
    bus.lpif_state_req = 4'd1;
    hs("rc_f", 1'b0, 1'b1, 4'd12, 4'd12);
    bus.force_detect = 1'b1;
    bus.finish_tx = 1'b1; bus.goto_tx = 4'd13;
    bus.finish_rx = 1'b1; bus.goto_rx = 4'd13;
    e_sts = 4'd0; e_lu = 1'b0; e_gen = 3'd1;
    step("force", 4'd0);
    e_wid = 2'd0;
    step("force_wid", 4'd0);

    // Asynchronous reset mid-L0, observed before any clock edge.
    hs("dq_to_da4", 1'b0, 1'b1, 4'd1, 4'd1);
    train_to(9);
    enter_l0();
    retrain(3'd5, 3'd5, 2'd1);
    #2 reset = 1'b0;
    #1;
    e_sub = 4'd0; e_sts = 4'd0; e_lu = 1'b0; e_gen = 3'd1;
    e_wid = 2'd0; e_nl = 5'd0; e_evt = 1'b0;
    push("async_reset");
    compare_now();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
